// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-bank constants and the write-arbiter state type.
// Imported by the arbiter, its interface and any future bank schedulers.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side request bundle plus the registered register-bank write port.
// master = requesters/bank side, slave = arbiter.
interface regfile_wr_arbiter_if
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [ID_W-1:0]         grant_id;
    logic                    locked;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, grant_id, locked
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, grant_id, locked
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after i_start, wrapping; combinational.
// No backpressure of its own; o_grant is zero when no request is set.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IDX_W'((int'(i_start) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx       = w_j;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter with lockable bursts; registered write one cycle after grant.
// req_ready is a combinational one-hot grant; non-granted requesters stall while valid.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int LOCK_MAX = 16,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_wr_arbiter_if.slave bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] LOCK_SAT  = CNT_W'(LOCK_MAX);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_owner;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ID_W-1:0]   r_grant_id;

    logic [ADDR_W-1:0] w_addr [N_REQ];
    logic [DATA_W-1:0] w_data [N_REQ];
    logic [N_REQ-1:0]  w_pick_grant;
    logic [ID_W-1:0]   w_pick_idx;
    logic [N_REQ-1:0]  w_ready;
    logic [ID_W-1:0]   w_idx;
    logic              w_xfer;
    logic              w_xfer_lock;
    logic              w_release;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_addr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign w_data[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(.N(N_REQ), .IDX_W(ID_W)) u_pick (
        .i_req   (bus.req_valid),
        .i_start (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    // While locked only the owner may be granted, even if it is idle this cycle.
    always_comb begin
        w_ready = '0;
        if (rst_n) begin
            if (r_state == IDLE) w_ready = w_pick_grant;
            else                 w_ready[r_owner] = bus.req_valid[r_owner];
        end
    end

    assign w_idx       = (r_state == IDLE) ? w_pick_idx : r_owner;
    assign w_xfer      = |w_ready;
    assign w_xfer_lock = w_xfer && bus.req_lock[w_idx];
    // Forced release also covers a count that saturated while the owner kept re-locking.
    assign w_release   = (w_xfer && !w_xfer_lock) ||
                         ((r_lock_cnt >= LOCK_LAST) && !w_xfer_lock);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_addr  <= w_addr[w_idx];
                r_wr_data  <= w_data[w_idx];
                r_grant_id <= w_idx;
            end
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_rr_ptr <= (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
                        if (w_xfer_lock) begin
                            r_state    <= LOCKED;
                            r_owner    <= w_idx;
                            r_lock_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (r_lock_cnt != LOCK_SAT) r_lock_cnt <= r_lock_cnt + 1'b1;
                    if (w_release) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.grant_id  = r_grant_id;
    assign bus.locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue/array-level arbitration model.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int N  = 4;
    localparam int LM = 4;
    localparam int AW = REG_ADDR_W;
    localparam int DW = REG_DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    regfile_wr_arbiter #(.N_REQ(N), .LOCK_MAX(LM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who owns the port and where the search starts next.
    bit          m_locked;
    int          m_owner, m_ptr, m_cnt;
    bit          m_wr_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_gid;
    bit          armed = 0;

    int            seen_gid[$];
    logic [DW-1:0] seen_data[$];
    logic [DW-1:0] bank [REG_COUNT];

    function automatic int model_pick();
        if (!rst_n) return -1;
        if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (bus.req_valid[j]) return j;
        end
        return -1;
    endfunction

    initial begin
        int g;
        bit keep;
        logic [N-1:0] er;
        forever begin
            @(negedge clk);
            g  = model_pick();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            if (armed) begin
                check("req_ready", bus.req_ready, er);
                check("wr_en",     bus.wr_en, m_wr_en);
                check("wr_addr",   bus.wr_addr, m_addr);
                check("wr_data",   bus.wr_data, m_data);
                check("grant_id",  bus.grant_id, m_gid);
                check("locked",    bus.locked, m_locked);
                if (bus.wr_en === 1'b1) begin
                    seen_gid.push_back(int'(bus.grant_id));
                    seen_data.push_back(bus.wr_data);
                    bank[bus.wr_addr] = bus.wr_data;
                end
            end
            if (!rst_n) begin
                m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
                m_wr_en = 0; m_addr = '0; m_data = '0; m_gid = 0;
                armed = 1;
            end else begin
                m_wr_en = (g >= 0);
                if (g >= 0) begin
                    m_addr = bus.req_addr[g*AW +: AW];
                    m_data = bus.req_data[g*DW +: DW];
                    m_gid  = g;
                end
                if (!m_locked) begin
                    if (g >= 0) begin
                        m_ptr = (g + 1) % N;
                        if (bus.req_lock[g]) begin
                            m_locked = 1; m_owner = g; m_cnt = 0;
                        end
                    end
                end else begin
                    keep = (g >= 0) && bus.req_lock[g];
                    if (((g >= 0) && !keep) || (m_cnt >= LM - 1 && !keep)) m_locked = 0;
                    m_cnt = (m_cnt < LM) ? m_cnt + 1 : LM;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int lk;
        bit got;
        int exp_rr[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_lock[5] = '{1, 1, 1, 2, 0};

        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        rst_n = 1'b0;
        repeat (2) cyc();

        // Reset state, then a single write appears exactly one cycle later.
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        set_req(0, 5'd5, 32'hDEADBEEF);
        bus.req_valid = 4'b0001;
        #1;
        check("first_ready", bus.req_ready, 4'b0001);
        cyc();
        bus.req_valid = '0;
        check("first_wr_en", bus.wr_en, 1);
        check("first_wr_addr", bus.wr_addr, 5);
        check("first_wr_data", bus.wr_data, 32'hDEADBEEF);
        cyc();
        check("first_pulse_single", bus.wr_en, 0);

        // Round-robin fairness from rr_ptr = 0.
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        seen_gid.delete();
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 8), DW'(32'hA0 + i));
        bus.req_valid = 4'b1111;
        repeat (8) cyc();
        bus.req_valid = '0;
        cyc();
        check("rr_count", seen_gid.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < seen_gid.size()) check($sformatf("rr_grant%0d", i), seen_gid[i], exp_rr[i]);

        // Lock burst by req1 while req0 and req2 wait.
        bus.req_valid = 4'b0001; cyc(); bus.req_valid = '0; cyc();
        seen_gid.delete();
        bus.req_valid = 4'b0111;
        bus.req_lock  = 4'b0010;
        cyc();
        check("burst_locked", bus.locked, 1);
        cyc();
        bus.req_lock = '0;
        cyc();
        check("burst_unlocked", bus.locked, 0);
        bus.req_valid = 4'b0101;
        repeat (2) cyc();
        bus.req_valid = '0;
        cyc();
        check("burst_count", seen_gid.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < seen_gid.size()) check($sformatf("burst_grant%0d", i), seen_gid[i], exp_lock[i]);

        // Forced release: req3 locks then goes idle while req0 waits.
        bus.req_valid = 4'b1000;
        bus.req_lock  = 4'b1000;
        cyc();
        bus.req_valid = 4'b0001;
        bus.req_lock  = '0;
        #1;
        lk = 0; got = 0;
        for (int t = 0; t < 20; t++) begin
            if (bus.req_ready[0]) begin got = 1; break; end
            if (bus.locked) lk++;
            cyc();
        end
        check("force_grant_seen", got, 1);
        check("force_locked_cycles", lk, LM);
        check("force_locked_low", bus.locked, 0);
        cyc();
        bus.req_valid = '0;
        cyc();

        // Reset pulsed during a locked req2 transfer.
        bus.req_valid = 4'b0100;
        bus.req_lock  = 4'b0100;
        cyc();
        check("midrst_locked_before", bus.locked, 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_locked", bus.locked, 0);
        bus.req_lock  = '0;
        bus.req_valid = 4'b1111;
        #1;
        check("midrst_next_grant", bus.req_ready, 4'b0001);
        cyc();
        bus.req_valid = '0;
        cyc();

        // Same address from two requesters: later grant wins.
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        seen_data.delete();
        set_req(0, 5'd7, 32'h11);
        set_req(1, 5'd7, 32'h22);
        bus.req_valid = 4'b0011;
        cyc();
        bus.req_valid = 4'b0010;
        cyc();
        bus.req_valid = '0;
        repeat (2) cyc();
        check("same_addr_count", seen_data.size(), 2);
        if (seen_data.size() == 2) begin
            check("same_addr_first", seen_data[0], 32'h11);
            check("same_addr_second", seen_data[1], 32'h22);
        end
        check("same_addr_bank7", bank[7], 32'h22);

        // Random traffic with occasional resets and lock requests.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                bus.req_lock[i]  = ($urandom_range(0, 2) == 0);
                set_req(i, AW'($urandom), DW'($urandom));
            end
            cyc();
        end
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        repeat (LM + 3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
